// File: rtl/mmio_ram_arbiter_if.sv
// mmio_ram_arbiter_if
//   Bundles the CPU load/store handshake and the single RAM access port that
//   the arbiter sits between.
//   slave  : arbiter side (takes CPU requests, drives the RAM port)
//   master : environment side (CPU requester plus the RAM itself)
//   CPU  : cpu_req/cpu_wEn/cpu_addr/cpu_dataIn in, cpu_dataOut/cpu_ack out
//   RAM  : ram_wEn/ram_addr/ram_dataIn registered out, ram_dataOut in
interface mmio_ram_arbiter_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     cpu_req;
  logic                     cpu_wEn;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_dataIn;
  logic [DATA_WIDTH-1:0]    cpu_dataOut;
  logic                     cpu_ack;

  logic                     ram_wEn;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_dataIn;
  logic [DATA_WIDTH-1:0]    ram_dataOut;

  modport slave (
    input  cpu_req, cpu_wEn, cpu_addr, cpu_dataIn,
    output cpu_dataOut, cpu_ack,
    output ram_wEn, ram_addr, ram_dataIn,
    input  ram_dataOut
  );

  modport master (
    output cpu_req, cpu_wEn, cpu_addr, cpu_dataIn,
    input  cpu_dataOut, cpu_ack,
    input  ram_wEn, ram_addr, ram_dataIn,
    output ram_dataOut
  );
endinterface

// File: rtl/mmio_ram_arbiter.sv
// mmio_ram_arbiter
//   Shares the single MMIO RAM port between CPU loads/stores and a refresh
//   engine. Every REFRESH_PERIOD cycles a refresh pass is triggered: it writes
//   num (addr 5) and remainder (addr 10) into RAM, then reads addrs 5, 6, 7, 11
//   back into LED[15:12], LED[11:0], remainder_led and mode. CPU and refresh
//   alternate when both want the port.
// Ports
//   clk, reset_n         : clock, asynchronous active-low reset
//   bus (slave modport)  : CPU handshake and registered RAM access port
//   num, remainder       : peripheral inputs written by each pass
//   LED, remainder_led,
//   mode                 : registered board outputs loaded by each pass
//   refresh_overrun      : sticky flag, trigger arrived while a pass was busy
module mmio_ram_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 12,
  parameter int REFRESH_PERIOD = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  mmio_ram_arbiter_if.slave   bus,
  input  logic [3:0]          num,
  input  logic [31:0]         remainder,
  output logic [15:0]         LED,
  output logic                remainder_led,
  output logic                mode,
  output logic                refresh_overrun
);

  localparam int CW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_PERIOD - 1);
  localparam logic [2:0]    LAST_STEP = 3'd5;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_NUM  = ADDRESS_WIDTH'(5);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LED  = ADDRESS_WIDTH'(6);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_RLED = ADDRESS_WIDTH'(7);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_REM  = ADDRESS_WIDTH'(10);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MODE = ADDRESS_WIDTH'(11);

  typedef enum logic [2:0] {
    IDLE,
    CPU_WR,
    CPU_RD,
    CPU_RDCAP,
    REF_WR,
    REF_RD,
    REF_RDCAP
  } state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_REF
  } grant_t;

  state_t                   state, state_nx;
  grant_t                   last_gnt, last_gnt_nx;
  logic [2:0]               step;
  logic [CW-1:0]            ref_cnt;
  logic                     ref_pend;
  logic                     cnt_wrap;
  logic                     step_done;
  logic                     pass_done;

  logic                     ram_wen_q, ram_wen_nx;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_nx;
  logic [DATA_WIDTH-1:0]    ram_din_q, ram_din_nx;
  logic [DATA_WIDTH-1:0]    step_wdata;

  logic                     cpu_ack_q;
  logic [DATA_WIDTH-1:0]    cpu_dout_q;

  function automatic logic [ADDRESS_WIDTH-1:0] step_addr(input logic [2:0] s);
    case (s)
      3'd0:    step_addr = ADDR_NUM;
      3'd1:    step_addr = ADDR_REM;
      3'd2:    step_addr = ADDR_NUM;
      3'd3:    step_addr = ADDR_LED;
      3'd4:    step_addr = ADDR_RLED;
      default: step_addr = ADDR_MODE;
    endcase
  endfunction

  // Only steps 0 and 1 write; the peripheral value is taken on the grant edge
  // so it is what the RAM sees throughout the access cycle.
  assign step_wdata = (step == 3'd0) ? DATA_WIDTH'({28'd0, num})
                                     : DATA_WIDTH'(remainder);

  assign cnt_wrap  = (ref_cnt == CNT_LAST);
  assign pass_done = step_done && (step == LAST_STEP);

  // Arbitration and access sequencing. The RAM port values are computed here
  // and registered, so they appear exactly in the access cycle that follows a
  // grant; the registered copy also serves as the latched CPU request.
  always_comb begin
    state_nx    = state;
    last_gnt_nx = last_gnt;
    ram_wen_nx  = 1'b0;
    ram_addr_nx = ram_addr_q;
    ram_din_nx  = ram_din_q;
    step_done   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.cpu_req && (!ref_pend || last_gnt == GNT_REF)) begin
          last_gnt_nx = GNT_CPU;
          ram_wen_nx  = bus.cpu_wEn;
          ram_addr_nx = bus.cpu_addr;
          ram_din_nx  = bus.cpu_dataIn;
          state_nx    = bus.cpu_wEn ? CPU_WR : CPU_RD;
        end else if (ref_pend) begin
          last_gnt_nx = GNT_REF;
          ram_addr_nx = step_addr(step);
          if (step < 3'd2) begin
            ram_wen_nx = 1'b1;
            ram_din_nx = step_wdata;
            state_nx   = REF_WR;
          end else begin
            state_nx = REF_RD;
          end
        end
      end
      CPU_WR:    state_nx = IDLE;
      CPU_RD:    state_nx = CPU_RDCAP;
      CPU_RDCAP: state_nx = IDLE;
      REF_WR: begin
        state_nx  = IDLE;
        step_done = 1'b1;
      end
      REF_RD:    state_nx = REF_RDCAP;
      REF_RDCAP: begin
        state_nx  = IDLE;
        step_done = 1'b1;
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_gnt   <= GNT_REF;
      ram_wen_q  <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state      <= state_nx;
      last_gnt   <= last_gnt_nx;
      ram_wen_q  <= ram_wen_nx;
      ram_addr_q <= ram_addr_nx;
      ram_din_q  <= ram_din_nx;
    end
  end

  // Refresh trigger and pass progress. A wrap on the very edge the final step
  // completes is not an overrun: that pass is finished and the new one starts
  // straight away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt         <= '0;
      ref_pend        <= 1'b0;
      refresh_overrun <= 1'b0;
      step            <= '0;
    end else begin
      ref_cnt <= cnt_wrap ? '0 : ref_cnt + 1'b1;

      if (cnt_wrap) begin
        if (ref_pend && !pass_done)
          refresh_overrun <= 1'b1;
        ref_pend <= 1'b1;
      end else if (pass_done) begin
        ref_pend <= 1'b0;
      end

      if (step_done)
        step <= pass_done ? '0 : step + 3'd1;
    end
  end

  // Completion and read-data capture. RAM read data is valid in the cycle
  // after the access cycle and is registered at the end of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_ack_q     <= 1'b0;
      cpu_dout_q    <= '0;
      LED           <= '0;
      remainder_led <= 1'b0;
      mode          <= 1'b0;
    end else begin
      cpu_ack_q <= (state == CPU_WR) || (state == CPU_RDCAP);

      if (state == CPU_RDCAP)
        cpu_dout_q <= bus.ram_dataOut;

      if (state == REF_RDCAP) begin
        case (step)
          3'd2:    LED[15:12]    <= bus.ram_dataOut[3:0];
          3'd3:    LED[11:0]     <= bus.ram_dataOut[11:0];
          3'd4:    remainder_led <= bus.ram_dataOut[0];
          3'd5:    mode          <= bus.ram_dataOut[0];
          default: ;
        endcase
      end
    end
  end

  assign bus.ram_wEn     = ram_wen_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_dataIn  = ram_din_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_dataOut = cpu_dout_q;

endmodule

// File: tb/tb_mmio_ram_arbiter.sv
// tb_mmio_ram_arbiter
//   Drives CPU transactions into mmio_ram_arbiter, models the RAM behind it,
//   and checks CPU responses and board outputs against a memory-level model.
module tb_mmio_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int RP = 16;
  localparam int MAX_LAT = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  num;
  logic [31:0] remainder;
  logic [15:0] LED;
  logic        remainder_led;
  logic        mode;
  logic        refresh_overrun;

  mmio_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  mmio_ram_arbiter #(
    .DATA_WIDTH(DW),
    .ADDRESS_WIDTH(AW),
    .REFRESH_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave),
    .num(num),
    .remainder(remainder),
    .LED(LED),
    .remainder_led(remainder_led),
    .mode(mode),
    .refresh_overrun(refresh_overrun)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write on the access edge, read data one cycle later.
  logic [DW-1:0] mem [0:4095] = '{default: '0};
  always @(posedge clk) begin
    if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_dataIn;
    bus.ram_dataOut <= mem[bus.ram_addr];
  end

  // Reference: contents the RAM should hold from CPU stores alone.
  logic [DW-1:0] ref_mem [0:4095] = '{default: '0};

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_cpu_ack"},     {31'd0, bus.cpu_ack}, 32'd0);
    check({tag, "_cpu_dataOut"}, bus.cpu_dataOut, 32'd0);
    check({tag, "_LED"},         {16'd0, LED}, 32'd0);
    check({tag, "_rled"},        {31'd0, remainder_led}, 32'd0);
    check({tag, "_mode"},        {31'd0, mode}, 32'd0);
    check({tag, "_overrun"},     {31'd0, refresh_overrun}, 32'd0);
    check({tag, "_ram_wEn"},     {31'd0, bus.ram_wEn}, 32'd0);
    check({tag, "_ram_addr"},    {20'd0, bus.ram_addr}, 32'd0);
    check({tag, "_ram_dataIn"},  bus.ram_dataIn, 32'd0);
  endtask

  // Board outputs after a completed pass: num, then RAM words 6, 7, 11.
  task automatic check_board(input string tag);
    logic [DW-1:0] w6, w7, w11;
    w6 = ref_mem[6]; w7 = ref_mem[7]; w11 = ref_mem[11];
    check({tag, "_LED"},  {16'd0, LED}, {16'd0, num, w6[11:0]});
    check({tag, "_rled"}, {31'd0, remainder_led}, {31'd0, w7[0]});
    check({tag, "_mode"}, {31'd0, mode}, {31'd0, w11[0]});
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle with
  // cpu_req already dropped so the ack cycle does not start another access.
  task automatic cpu_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    int   lat;
    bit   done;
    t.wr = wr; t.addr = a; t.data = wr ? d : ref_mem[a];
    if (wr) ref_mem[a] = d;
    sb_q.push_back(t);
    bus.cpu_req = 1'b1; bus.cpu_wEn = wr; bus.cpu_addr = a; bus.cpu_dataIn = d;
    lat = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ack) done = 1;
      else if (lat >= MAX_LAT) begin
        checks++; errors++;
        $display("FAIL cpu_latency: no cpu_ack after %0d cycles, required within %0d (addr 0x%0h)", lat, MAX_LAT, a);
        void'(sb_q.pop_back());
        done = 1;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr(input bit board_words);
    int unsigned i;
    i = $urandom_range(0, board_words ? 18 : 15);
    if (i == 16) return AW'(6);
    if (i == 17) return AW'(7);
    if (i == 18) return AW'(11);
    return AW'(32 + i);
  endfunction

  // Monitor: checks refresh writes on the RAM bus and pops the scoreboard on
  // every cpu_ack, verifying data and the access cycle position.
  txn_t          mt;
  logic          h1_wen, h2_wen;
  logic [AW-1:0] h1_addr, h2_addr;
  logic [DW-1:0] h1_din;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.ram_wEn && bus.ram_addr == AW'(5))
        check("ref_wr_num", bus.ram_dataIn, {28'd0, num});
      if (bus.ram_wEn && bus.ram_addr == AW'(10))
        check("ref_wr_rem", bus.ram_dataIn, remainder);
      if (bus.cpu_ack) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: cpu_ack=1 with no outstanding request, required 0");
        end else begin
          mt = sb_q.pop_front();
          if (mt.wr) begin
            check("wr_access_cycle", {19'd0, h1_wen, h1_addr}, {19'd0, 1'b1, mt.addr});
            check("wr_access_data", h1_din, mt.data);
          end else begin
            check("rd_access_cycle", {19'd0, h2_wen, h2_addr}, {19'd0, 1'b0, mt.addr});
            check("rd_data", bus.cpu_dataOut, mt.data);
          end
        end
      end
    end
    h2_wen = h1_wen; h2_addr = h1_addr;
    h1_wen = bus.ram_wEn; h1_addr = bus.ram_addr; h1_din = bus.ram_dataIn;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: run still active at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          found;
    logic [DW-1:0] d;

    bus.cpu_req = 1'b0; bus.cpu_wEn = 1'b0; bus.cpu_addr = '0; bus.cpu_dataIn = '0;
    num = 4'hA; remainder = 32'h1234;

    // Reset and first refresh pass
    #2 reset_n = 1'b0;
    wait_cycles(3);
    check_reset_zero("reset");
    reset_n = 1'b1;
    wait_cycles(40);
    check("t1_LED_num", {28'd0, LED[15:12]}, {28'd0, num});
    check("t1_overrun", {31'd0, refresh_overrun}, 32'd0);
    check("t1_ram5", mem[5], {28'd0, num});
    check("t1_ram10", mem[10], remainder);
    check_board("t1");

    // CPU write then read of the LED word
    cpu_txn(1'b1, AW'(6), 32'h0000_0ABC);
    cpu_txn(1'b0, AW'(6), '0);
    wait_cycles(40);
    check_board("t2");

    // Indicator and mode words
    cpu_txn(1'b1, AW'(11), 32'd1);
    cpu_txn(1'b1, AW'(7), 32'd1);
    wait_cycles(40);
    check_board("t3a");
    cpu_txn(1'b1, AW'(11), 32'd0);
    wait_cycles(40);
    check_board("t3b");

    // Random mixed traffic, including board words
    repeat (40) begin
      d = $urandom;
      cpu_txn(1'($urandom_range(0, 1)), pick_addr(1'b1), d);
      wait_cycles($urandom_range(0, 3));
    end
    wait_cycles(40);
    check_board("mixed");

    // Fresh reset, new peripheral values, then continuous CPU pressure
    reset_n = 1'b0;
    num = 4'($urandom_range(1, 15));
    remainder = $urandom;
    #1 check_reset_zero("t4_reset");
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(40);
    check("t4_overrun_idle", {31'd0, refresh_overrun}, 32'd0);
    check_board("t4_pre");
    repeat (60) begin
      d = $urandom;
      cpu_txn(1'($urandom_range(0, 1)), pick_addr(1'b0), d);
    end
    check_board("t4_under_load");
    check("t5_overrun_set", {31'd0, refresh_overrun}, 32'd1);
    wait_cycles(40);
    check("t5_overrun_sticky", {31'd0, refresh_overrun}, 32'd1);

    // Reset during a CPU read access cycle
    d = $urandom;
    cpu_txn(1'b1, AW'(200), d);
    d = $urandom | 32'd1;
    cpu_txn(1'b1, AW'(201), d);
    cpu_txn(1'b0, AW'(201), '0);
    mt.wr = 1'b0; mt.addr = AW'(200); mt.data = ref_mem[200];
    sb_q.push_back(mt);
    bus.cpu_req = 1'b1; bus.cpu_wEn = 1'b0; bus.cpu_addr = AW'(200);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (bus.ram_addr == AW'(200) && !bus.ram_wEn) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL t6_find_access: CPU_RD access to 0x0c8 not seen within 12 cycles");
    end
    reset_n = 1'b0;
    #1 check_reset_zero("t6_reset");
    sb_q.delete();
    bus.cpu_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_no_ack", {31'd0, bus.cpu_ack}, 32'd0);
    end
    reset_n = 1'b1;
    cpu_txn(1'b0, AW'(6), '0);
    wait_cycles(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
